decode_queue: RTL

Buffered, parametrised instruction decode stage sitting between instruction fetch and the issue/dispatch unit. Fetched instructions are pushed into a DEPTH-entry circular queue with their PC and branch prediction. The head entry is decoded into op type, register indices, immediate and legality, and held in a registered output slot under a valid/ready handshake. It adds RV32M decode, illegal-instruction detection and a single-cycle flush for mispredict recovery.

---
 rtl/decode_pkg.sv | 114 +++++++++++
 rtl/rv_decode_core.sv | 164 ++++++++++++++++
 rtl/decode_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: op-type codes, RV32 opcode constants, the queue entry and
// output-slot records, and immediate-extraction helpers shared by the
// decode queue and its combinational decoder.
package decode_pkg;

  localparam int OP_W = 6;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP    = 6'd0;
  localparam op_t OP_LUI    = 6'd1;
  localparam op_t OP_AUIPC  = 6'd2;
  localparam op_t OP_JAL    = 6'd3;
  localparam op_t OP_JALR   = 6'd4;
  localparam op_t OP_BEQ    = 6'd5;
  localparam op_t OP_BNE    = 6'd6;
  localparam op_t OP_BLT    = 6'd7;
  localparam op_t OP_BGE    = 6'd8;
  localparam op_t OP_BLTU   = 6'd9;
  localparam op_t OP_BGEU   = 6'd10;
  localparam op_t OP_LB     = 6'd11;
  localparam op_t OP_LH     = 6'd12;
  localparam op_t OP_LW     = 6'd13;
  localparam op_t OP_LBU    = 6'd14;
  localparam op_t OP_LHU    = 6'd15;
  localparam op_t OP_SB     = 6'd16;
  localparam op_t OP_SH     = 6'd17;
  localparam op_t OP_SW     = 6'd18;
  localparam op_t OP_ADDI   = 6'd19;
  localparam op_t OP_SLTI   = 6'd20;
  localparam op_t OP_SLTIU  = 6'd21;
  localparam op_t OP_XORI   = 6'd22;
  localparam op_t OP_ORI    = 6'd23;
  localparam op_t OP_ANDI   = 6'd24;
  localparam op_t OP_SLLI   = 6'd25;
  localparam op_t OP_SRLI   = 6'd26;
  localparam op_t OP_SRAI   = 6'd27;
  localparam op_t OP_ADD    = 6'd28;
  localparam op_t OP_SUB    = 6'd29;
  localparam op_t OP_SLL    = 6'd30;
  localparam op_t OP_SLT    = 6'd31;
  localparam op_t OP_SLTU   = 6'd32;
  localparam op_t OP_XOR    = 6'd33;
  localparam op_t OP_SRL    = 6'd34;
  localparam op_t OP_SRA    = 6'd35;
  localparam op_t OP_OR     = 6'd36;
  localparam op_t OP_AND    = 6'd37;
  localparam op_t OP_MUL    = 6'd38;
  localparam op_t OP_MULH   = 6'd39;
  localparam op_t OP_MULHSU = 6'd40;
  localparam op_t OP_MULHU  = 6'd41;
  localparam op_t OP_DIV    = 6'd42;
  localparam op_t OP_DIVU   = 6'd43;
  localparam op_t OP_REM    = 6'd44;
  localparam op_t OP_REMU   = 6'd45;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // One queued fetch: raw word is kept, decode happens at the head.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_jump;
  } q_entry_t;

  // Registered output slot contents.
  typedef struct packed {
    logic [31:0] pc;
    op_t         op_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        pred_jump;
    logic        illegal;
  } slot_t;

  localparam slot_t SLOT_RESET = '{
    pc: 32'd0, op_type: OP_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
    imm: 32'd0, pred_jump: 1'b0, illegal: 1'b0
  };

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv_decode_core.sv
// rv_decode_core: purely combinational RV32I (+ optional RV32M) decoder.
//   inst     : raw 32-bit instruction word
//   op_type  : decoded op (OP_NOP when illegal)
//   rd/rs1/rs2 : register indices, zero where the format has no such field
//   imm      : sign-extended, format-specific immediate (shamt for shifts)
//   illegal  : opcode/funct3/funct7 combination not recognised
// Illegal words report zero register indices and a zero immediate.
module rv_decode_core
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] inst,
  output op_t         op_type,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  op_t         op_c;
  logic [4:0]  rd_c;
  logic [4:0]  rs1_c;
  logic [4:0]  rs2_c;
  logic [31:0] imm_c;
  logic        legal_c;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  always_comb begin
    op_c    = OP_NOP;
    rd_c    = 5'd0;
    rs1_c   = 5'd0;
    rs2_c   = 5'd0;
    imm_c   = 32'd0;
    legal_c = 1'b0;
    case (opcode)
      OPC_LUI: begin
        op_c = OP_LUI; rd_c = inst[11:7]; imm_c = imm_u(inst); legal_c = 1'b1;
      end
      OPC_AUIPC: begin
        op_c = OP_AUIPC; rd_c = inst[11:7]; imm_c = imm_u(inst); legal_c = 1'b1;
      end
      OPC_JAL: begin
        op_c = OP_JAL; rd_c = inst[11:7]; imm_c = imm_j(inst); legal_c = 1'b1;
      end
      OPC_JALR: begin
        // Only funct3 = 000 is a defined JALR encoding.
        op_c = OP_JALR; rd_c = inst[11:7]; rs1_c = inst[19:15];
        imm_c = imm_i(inst); legal_c = (f3 == 3'd0);
      end
      OPC_BRANCH: begin
        rs1_c = inst[19:15]; rs2_c = inst[24:20]; imm_c = imm_b(inst);
        legal_c = 1'b1;
        case (f3)
          3'd0:    op_c = OP_BEQ;
          3'd1:    op_c = OP_BNE;
          3'd4:    op_c = OP_BLT;
          3'd5:    op_c = OP_BGE;
          3'd6:    op_c = OP_BLTU;
          3'd7:    op_c = OP_BGEU;
          default: legal_c = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        rd_c = inst[11:7]; rs1_c = inst[19:15]; imm_c = imm_i(inst);
        legal_c = 1'b1;
        case (f3)
          3'd0:    op_c = OP_LB;
          3'd1:    op_c = OP_LH;
          3'd2:    op_c = OP_LW;
          3'd4:    op_c = OP_LBU;
          3'd5:    op_c = OP_LHU;
          default: legal_c = 1'b0;
        endcase
      end
      OPC_STORE: begin
        rs1_c = inst[19:15]; rs2_c = inst[24:20]; imm_c = imm_s(inst);
        legal_c = 1'b1;
        case (f3)
          3'd0:    op_c = OP_SB;
          3'd1:    op_c = OP_SH;
          3'd2:    op_c = OP_SW;
          default: legal_c = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        rd_c = inst[11:7]; rs1_c = inst[19:15]; imm_c = imm_i(inst);
        legal_c = 1'b1;
        case (f3)
          3'd0: op_c = OP_ADDI;
          3'd2: op_c = OP_SLTI;
          3'd3: op_c = OP_SLTIU;
          3'd4: op_c = OP_XORI;
          3'd6: op_c = OP_ORI;
          3'd7: op_c = OP_ANDI;
          // Shifts carry funct7 in the upper immediate bits; the immediate
          // handed downstream is just the 5-bit shift amount.
          3'd1: begin
            op_c = OP_SLLI; imm_c = {27'd0, inst[24:20]};
            legal_c = (f7 == F7_BASE);
          end
          default: begin
            imm_c = {27'd0, inst[24:20]};
            if (f7 == F7_BASE)     op_c = OP_SRLI;
            else if (f7 == F7_ALT) op_c = OP_SRAI;
            else                   legal_c = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        rd_c = inst[11:7]; rs1_c = inst[19:15]; rs2_c = inst[24:20];
        legal_c = 1'b1;
        if (f7 == F7_MULDIV) begin
          legal_c = EN_M;
          case (f3)
            3'd0:    op_c = OP_MUL;
            3'd1:    op_c = OP_MULH;
            3'd2:    op_c = OP_MULHSU;
            3'd3:    op_c = OP_MULHU;
            3'd4:    op_c = OP_DIV;
            3'd5:    op_c = OP_DIVU;
            3'd6:    op_c = OP_REM;
            default: op_c = OP_REMU;
          endcase
        end else begin
          case (f3)
            3'd0: begin
              if (f7 == F7_BASE)     op_c = OP_ADD;
              else if (f7 == F7_ALT) op_c = OP_SUB;
              else                   legal_c = 1'b0;
            end
            3'd5: begin
              if (f7 == F7_BASE)     op_c = OP_SRL;
              else if (f7 == F7_ALT) op_c = OP_SRA;
              else                   legal_c = 1'b0;
            end
            3'd1:    begin op_c = OP_SLL;  legal_c = (f7 == F7_BASE); end
            3'd2:    begin op_c = OP_SLT;  legal_c = (f7 == F7_BASE); end
            3'd3:    begin op_c = OP_SLTU; legal_c = (f7 == F7_BASE); end
            3'd4:    begin op_c = OP_XOR;  legal_c = (f7 == F7_BASE); end
            3'd6:    begin op_c = OP_OR;   legal_c = (f7 == F7_BASE); end
            default: begin op_c = OP_AND;  legal_c = (f7 == F7_BASE); end
          endcase
        end
      end
      default: legal_c = 1'b0;
    endcase
  end

  assign op_type = legal_c ? op_c  : OP_NOP;
  assign rd      = legal_c ? rd_c  : 5'd0;
  assign rs1     = legal_c ? rs1_c : 5'd0;
  assign rs2     = legal_c ? rs2_c : 5'd0;
  assign imm     = legal_c ? imm_c : 32'd0;
  assign illegal = !legal_c;

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry circular fetch queue feeding a registered
// decode output slot.
//   clk, rst          : rising-edge clock, async active-high reset
//   rdy               : global enable; low freezes every register
//   flush             : drop queue contents and the output slot
//   in_valid/in_ready, in_pc, in_inst, in_pred_jump : fetch side
//   out_valid/out_ready, out_pc, out_op_type, out_rd/rs1/rs2, out_imm,
//   out_pred_jump, out_illegal : issue side
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit EN_M  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_pred_jump,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [OP_W-1:0] out_op_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic            out_pred_jump,
  output logic            out_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready
  // && rdy && !flush. Valid never depends on ready on either side; in_ready
  // depends only on the stored count, so a pop in the same cycle does not
  // open a slot for a push while full.

  q_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  slot_t            slot_q, slot_d;

  logic     push;
  logic     pop;
  logic     slot_free;
  q_entry_t head_entry;
  q_entry_t in_entry;

  op_t         dec_op;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  assign in_ready   = (count_q != FULL_CNT);
  assign head_entry = mem_q[head_q];
  assign in_entry   = '{pc: in_pc, inst: in_inst, pred_jump: in_pred_jump};

  rv_decode_core #(.EN_M(EN_M)) u_core (
    .inst    (head_entry.inst),
    .op_type (dec_op),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    push        = rdy && !flush && in_valid && in_ready;
    slot_free   = !out_valid_q || out_ready;
    pop         = rdy && !flush && (count_q != '0) && slot_free;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    if (rdy && flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop) begin
        // Head decode moves into the slot on the edge that pops it.
        head_d      = head_q + 1'b1;
        out_valid_d = 1'b1;
        slot_d      = '{pc: head_entry.pc, op_type: dec_op, rd: dec_rd,
                        rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm,
                        pred_jump: head_entry.pred_jump,
                        illegal: dec_illegal};
      end else if (rdy && out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      slot_q      <= SLOT_RESET;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
    end
  end

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_entry;
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = slot_q.pc;
  assign out_op_type   = slot_q.op_type;
  assign out_rd        = slot_q.rd;
  assign out_rs1       = slot_q.rs1;
  assign out_rs2       = slot_q.rs2;
  assign out_imm       = slot_q.imm;
  assign out_pred_jump = slot_q.pred_jump;
  assign out_illegal   = slot_q.illegal;

endmodule
